// File: rtl/xi_graph_readback.sv
// xi_graph_readback: AXI4 read-channel slave that returns graph nodes from
// the PL graph BRAM to the PS. Each 160-bit node sits in a 32-byte slot and
// is returned as four 64-bit words (word3 always reads as zero).
//
// Optional feature macro: XI_READBACK_WRAP_EN
//   defined   -> WRAP bursts with arlen in {1,3,7,15} use wrap addressing
//   undefined -> every WRAP burst returns SLVERR on every beat, no memory reads
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. Once valid is raised it stays high, with its payload held
// constant, until that transfer. Ready may toggle freely and never depends on
// valid being held off. The BRAM port follows the same rule with mem_req as
// valid and mem_gnt as ready; mem_rd_data is valid one cycle after the
// granted read.
module xi_graph_readback #(
  parameter int ADDR_W   = 16,
  parameter int AXI_ADDR = 32
) (
  input  logic                clk,
  input  logic                rst,
  // AR channel
  input  logic [AXI_ADDR-1:0] s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  // R channel
  output logic [63:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  // graph BRAM read port (shared with the multi-core engine)
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [159:0]        mem_rd_data,
  // status
  output logic                rb_busy,
  output logic [1:0]          dbg_state_o
);

  // FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] SEND  = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]          state_q, state_d;
  logic [AXI_ADDR-1:0] addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [1:0]          burst_q, burst_d;
  logic [7:0]          bcnt_q, bcnt_d;
  logic                burst_err_q, burst_err_d;
  logic                arready_q;

  // node buffer: last node fetched in the current burst
  logic [159:0]        buf_q;
  logic                buf_vld_q;
  logic [ADDR_W-1:0]   buf_node_q;

  // ---------------------------------------------------------------------
  // Address helpers
  // ---------------------------------------------------------------------

  // Any address bit above the node index makes the beat an error.
  function automatic logic addr_hi_err(input logic [AXI_ADDR-1:0] a);
    return (a >> (ADDR_W + 5)) != '0;
  endfunction

  // Beat-level error: burst-wide flags plus alignment and range of this beat.
  function automatic logic beat_err_of(input logic                burst_err,
                                       input logic [AXI_ADDR-1:0] a);
    return burst_err || (a[2:0] != 3'b000) || addr_hi_err(a);
  endfunction

  logic                ar_hs;
  logic                r_hs;
  logic                wrap_ok_in;
  logic                burst_err_in;
  logic                first_err_in;

  logic [ADDR_W-1:0]   node_cur;
  logic [1:0]          word_cur;
  logic                beat_err;
  logic                last_beat;

  logic [AXI_ADDR-1:0] addr_nxt;
  logic [ADDR_W-1:0]   node_nxt;
  logic                err_nxt;
  logic                hit_nxt;
  logic [63:0]         word_data;

  assign ar_hs = s_axi_arvalid && arready_q;
  assign r_hs  = (state_q == SEND) && s_axi_rready;

  // Wrap eligibility of the incoming burst; only power-of-two beat counts wrap.
`ifdef XI_READBACK_WRAP_EN
  always_comb begin
    wrap_ok_in = 1'b0;
    case (s_axi_arlen)
      8'd1, 8'd3, 8'd7, 8'd15: wrap_ok_in = 1'b1;
      default:                 wrap_ok_in = 1'b0;
    endcase
  end
`else
  assign wrap_ok_in = 1'b0;
`endif

  // Burst-wide error flags of the incoming AR and the error state of beat 0.
  always_comb begin
    burst_err_in = (s_axi_arsize != 3'b011) ||
                   (s_axi_arburst == BURST_RSVD) ||
                   ((s_axi_arburst == BURST_WRAP) && !wrap_ok_in);
    first_err_in = beat_err_of(burst_err_in, s_axi_araddr);
  end

  // Decode of the current beat.
  always_comb begin
    node_cur  = addr_q[ADDR_W+4:5];
    word_cur  = addr_q[4:3];
    beat_err  = beat_err_of(burst_err_q, addr_q);
    last_beat = (bcnt_q == len_q);
  end

  // Address of the following beat; wrap keeps the upper bits of the window.
`ifdef XI_READBACK_WRAP_EN
  logic [AXI_ADDR-1:0] wrap_mask;
  assign wrap_mask = AXI_ADDR'({len_q, 3'b111});

  always_comb begin
    case (burst_q)
      BURST_FIXED: addr_nxt = addr_q;
      BURST_WRAP:  addr_nxt = (addr_q & ~wrap_mask) |
                              ((addr_q + AXI_ADDR'(8)) & wrap_mask);
      default:     addr_nxt = addr_q + AXI_ADDR'(8);
    endcase
  end
`else
  always_comb begin
    case (burst_q)
      BURST_FIXED: addr_nxt = addr_q;
      BURST_WRAP:  addr_nxt = addr_q;  // every beat is SLVERR, address unused
      default:     addr_nxt = addr_q + AXI_ADDR'(8);
    endcase
  end
`endif

  // Lookahead for the following beat: its node, error state and buffer hit.
  always_comb begin
    node_nxt = addr_nxt[ADDR_W+4:5];
    err_nxt  = beat_err_of(burst_err_q, addr_nxt);
    hit_nxt  = buf_vld_q && (buf_node_q == node_nxt);
  end

  // Word select out of the buffered node.
  always_comb begin
    word_data = 64'd0;
    case (word_cur)
      2'd0:    word_data = buf_q[63:0];
      2'd1:    word_data = buf_q[127:64];
      2'd2:    word_data = {32'd0, buf_q[159:128]};
      default: word_data = 64'd0;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM next-state and burst bookkeeping
  // ---------------------------------------------------------------------

  // Next-state logic: accept AR, fetch nodes on buffer miss, stream beats.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    burst_d     = burst_q;
    bcnt_d      = bcnt_q;
    burst_err_d = burst_err_q;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          addr_d      = s_axi_araddr;
          len_d       = s_axi_arlen;
          burst_d     = s_axi_arburst;
          bcnt_d      = 8'd0;
          burst_err_d = burst_err_in;
          state_d     = first_err_in ? SEND : FETCH;
        end
      end
      FETCH: begin
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        state_d = SEND;
      end
      SEND: begin
        if (r_hs) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_nxt;
            bcnt_d  = bcnt_q + 8'd1;
            state_d = (err_nxt || hit_nxt) ? SEND : FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= 8'd0;
      burst_q     <= BURST_FIXED;
      bcnt_q      <= 8'd0;
      burst_err_q <= 1'b0;
      arready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      bcnt_q      <= bcnt_d;
      burst_err_q <= burst_err_d;
      arready_q   <= (state_d == IDLE);
    end
  end

  // Node buffer: invalidated per burst, loaded in WAIT from the granted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
      buf_node_q <= '0;
    end else if (ar_hs) begin
      buf_vld_q  <= 1'b0;
    end else if (state_q == WAIT) begin
      buf_q      <= mem_rd_data;
      buf_vld_q  <= 1'b1;
      buf_node_q <= node_cur;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs (all derived from registered state, so stable through stalls)
  // ---------------------------------------------------------------------

  // Drive AXI, BRAM and status outputs from the current state.
  always_comb begin
    s_axi_arready = arready_q;
    s_axi_rvalid  = (state_q == SEND);
    s_axi_rdata   = ((state_q == SEND) && !beat_err) ? word_data : 64'd0;
    s_axi_rresp   = ((state_q == SEND) && beat_err) ? RESP_SLVERR : RESP_OKAY;
    s_axi_rlast   = (state_q == SEND) && last_beat;
    mem_req       = (state_q == FETCH);
    mem_rd_addr   = node_cur;
    rb_busy       = (state_q != IDLE);
    dbg_state_o   = state_q;
  end

endmodule
